// File: rtl/block_data_memory.sv
// block_data_memory
//  Block-wide backing store behind the 8-bit data cache. Accepts one 32-bit
//  block read or write at a time and completes it a fixed LATENCY clocks later,
//  signalling progress on a registered busywait.
//  Optional build macro: BLKMEM_STATS_EN adds saturating rd_count/wr_count.
module block_data_memory #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic              busywait
`ifdef BLKMEM_STATS_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic                op_write_reg, op_write_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [DATA_W-1:0]   data_reg, data_next;
   logic                busywait_reg, busywait_next;
   logic [DATA_W-1:0]   readdata_reg, readdata_next;
   logic [DATA_W-1:0]   mem_reg [DEPTH];

   // Completion happens on the edge where the countdown has already reached zero.
   logic complete;
   assign complete = (state_reg == BUSY) && (cnt_reg == '0);

   // Next-state logic: accept a single legal request in IDLE, count down in BUSY.
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      op_write_next = op_write_reg;
      addr_next     = addr_reg;
      data_next     = data_reg;
      busywait_next = busywait_reg;
      readdata_next = readdata_reg;
      unique case (state_reg)
         IDLE: begin
            // read and write together is illegal and simply ignored
            if (read ^ write) begin
               state_next    = BUSY;
               cnt_next      = CNT_LOAD;
               op_write_next = write;
               addr_next     = address;
               data_next     = writedata;
               busywait_next = 1'b1;
            end
         end
         BUSY: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else begin
               state_next    = IDLE;
               busywait_next = 1'b0;
               if (!op_write_reg) begin
                  readdata_next = mem_reg[addr_reg];
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Control and data-path registers; reset aborts any in-flight access.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         op_write_reg <= 1'b0;
         addr_reg     <= '0;
         data_reg     <= '0;
         busywait_reg <= 1'b0;
         readdata_reg <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         op_write_reg <= op_write_next;
         addr_reg     <= addr_next;
         data_reg     <= data_next;
         busywait_reg <= busywait_next;
         readdata_reg <= readdata_next;
      end
   end

   // Block storage; contents are cleared by reset, so this maps to registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (complete && op_write_reg) begin
         mem_reg[addr_reg] <= data_reg;
      end
   end

   assign readdata = readdata_reg;
   assign busywait = busywait_reg;

`ifdef BLKMEM_STATS_EN
   logic [15:0] rd_count_reg, wr_count_reg;

   // Saturating completion counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_count_reg <= '0;
         wr_count_reg <= '0;
      end else if (complete) begin
         if (!op_write_reg && rd_count_reg != 16'hFFFF) rd_count_reg <= rd_count_reg + 16'd1;
         if (op_write_reg && wr_count_reg != 16'hFFFF)  wr_count_reg <= wr_count_reg + 16'd1;
      end
   end

   assign rd_count = rd_count_reg;
   assign wr_count = wr_count_reg;
`endif

endmodule

// File: tb/tb_block_data_memory.sv
// tb_block_data_memory
//  Table of block accesses with hand-derived expected read data, pushed into a
//  scoreboard on issue and checked on busywait fall, plus hand-written
//  sequences for the illegal request, mid-access reset and address change.
module tb_block_data_memory;

   localparam int LAT = 5;

   logic        clock = 1'b0;
   logic        reset;
   logic        read, write;
   logic [5:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        busywait;
`ifdef BLKMEM_STATS_EN
   logic [15:0] rd_count, wr_count;
`endif

   block_data_memory #(.ADDR_W(6), .DATA_W(32), .LATENCY(LAT)) dut (
      .clock     (clock),
      .reset     (reset),
      .read      (read),
      .write     (write),
      .address   (address),
      .writedata (writedata),
      .readdata  (readdata),
      .busywait  (busywait)
`ifdef BLKMEM_STATS_EN
      ,
      .rd_count  (rd_count),
      .wr_count  (wr_count)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          is_wr;
      logic [5:0]  addr;
      logic [31:0] data;
      bit          perturb;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t        vecs [12];
   logic [31:0] exp_q [$];
   logic [31:0] last_read;
   int          checks = 0;
   int          errors = 0;
   int          n_rd = 0;
   int          n_wr = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic do_access(input bit is_wr, input logic [5:0] a, input logic [31:0] d,
                            input bit perturb, input logic [31:0] exp_rd);
      int cyc;
      logic [31:0] want;
      address   = a;
      writedata = d;
      read      = !is_wr;
      write     = is_wr;
      if (!is_wr) exp_q.push_back(exp_rd);
      @(posedge clock); #1;
      check("accept_busywait", {31'd0, busywait}, 32'd1);
      if (perturb) begin
         address   = ~a;
         writedata = $urandom;
      end
      cyc = 0;
      while (busywait === 1'b1 && cyc < LAT + 20) begin
         cyc++;
         @(posedge clock); #1;
      end
      read  = 1'b0;
      write = 1'b0;
      check("busy_cycles", 32'(cyc), 32'(LAT));
      if (!is_wr) begin
         want = exp_q.pop_front();
         check("readdata", readdata, want);
         last_read = want;
         n_rd++;
      end else begin
         check("readdata_hold", readdata, last_read);
         n_wr++;
      end
      $display("%s addr=%h data=%h readdata=%h busy=%0d", is_wr ? "WR" : "RD", a, d, readdata, cyc);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{0, 6'h05, 32'h0,        0, 32'h0};
      vecs[1]  = '{1, 6'h2A, 32'hDEADBEEF, 0, 32'h0};
      vecs[2]  = '{0, 6'h2A, 32'h0,        0, 32'hDEADBEEF};
      vecs[3]  = '{0, 6'h2A, 32'h0,        1, 32'hDEADBEEF};
      vecs[4]  = '{1, 6'h00, 32'hCAFEF00D, 0, 32'h0};
      vecs[5]  = '{1, 6'h3F, 32'hA5A5A5A5, 0, 32'h0};
      vecs[6]  = '{0, 6'h00, 32'h0,        0, 32'hCAFEF00D};
      vecs[7]  = '{0, 6'h3F, 32'h0,        0, 32'hA5A5A5A5};
      vecs[8]  = '{1, 6'h2A, 32'h01234567, 0, 32'h0};
      vecs[9]  = '{1, 6'h15, 32'h77777777, 1, 32'h0};
      vecs[10] = '{0, 6'h15, 32'h0,        0, 32'h77777777};
      vecs[11] = '{0, 6'h2A, 32'h0,        0, 32'h01234567};

      reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
      last_read = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      check("reset_busywait", {31'd0, busywait}, 32'd0);
      check("reset_readdata", readdata, 32'h0);

      // Back-to-back: each access is issued the cycle after the previous one ends.
      for (int i = 0; i < 12; i++) begin
         do_access(vecs[i].is_wr, vecs[i].addr, vecs[i].data, vecs[i].perturb, vecs[i].exp_rd);
      end

      // Illegal simultaneous read and write: never accepted.
      read = 1'b1; write = 1'b1; address = 6'h2A; writedata = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         check("illegal_busywait", {31'd0, busywait}, 32'd0);
      end
      read = 1'b0; write = 1'b0;
      check("illegal_readdata", readdata, last_read);
      $display("ILLEGAL rd+wr x3 busywait=%b", busywait);
      do_access(0, 6'h2A, 32'h0, 0, 32'h01234567);

`ifdef BLKMEM_STATS_EN
      check("rd_count", {16'd0, rd_count}, 32'(n_rd));
      check("wr_count", {16'd0, wr_count}, 32'(n_wr));
`endif

      // Reset during the second busy cycle of a write discards it.
      address = 6'h3F; writedata = 32'h12345678; write = 1'b1;
      @(posedge clock); #1;
      check("rst_accept", {31'd0, busywait}, 32'd1);
      @(posedge clock); #1;
      reset = 1'b1; write = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      check("rst_busywait", {31'd0, busywait}, 32'd0);
      check("rst_readdata", readdata, 32'h0);
      $display("RESET mid-write busywait=%b readdata=%h", busywait, readdata);
      last_read = '0;
      n_rd = 0;
      n_wr = 0;
`ifdef BLKMEM_STATS_EN
      check("rst_rd_count", {16'd0, rd_count}, 32'd0);
      check("rst_wr_count", {16'd0, wr_count}, 32'd0);
`endif
      do_access(0, 6'h3F, 32'h0, 0, 32'h0);
      do_access(0, 6'h2A, 32'h0, 0, 32'h0);

      // Idle cycles do not disturb readdata.
      repeat (3) @(posedge clock);
      #1;
      check("idle_hold", readdata, last_read);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
